// File: rtl/alu_result_sel_pipe.sv
// alu_result_sel_pipe
// Registered result selector with a 2-entry valid/ready output buffer.
// The opcode selects one of NUM_OPS packed results and its aux bit.
// The selected entry is flagged as zero or illegal when it is captured.
// The head entry drives out_*. The skid entry absorbs one extra transfer,
// so in_ready can be a plain register with no path from out_ready.
//
// Optional build macro: ALU_SEL_ERRCNT_EN adds an 8-bit saturating count of
// illegal-opcode transfers (err_cnt) and a synchronous clear input (err_clr).
//
// Occupancy states:
//   state | meaning
//   EMPTY | no entry held, out_valid=0, in_ready=1
//   ONE   | head holds an entry, skid empty, in_ready=1
//   TWO   | head and skid both hold entries, in_ready=0

module alu_result_sel_pipe #(
    parameter int W       = 8,
    parameter int NUM_OPS = 13,
    parameter int OPC_W   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [OPC_W-1:0]     in_opc,
    input  logic [NUM_OPS*W-1:0] res_bus,
    input  logic [NUM_OPS-1:0]   aux_bus,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W-1:0]         out_data,
    output logic                 out_aux,
    output logic                 out_zero,
    output logic                 out_illegal,
    output logic [OPC_W-1:0]     out_opc
`ifdef ALU_SEL_ERRCNT_EN
    ,
    input  logic                 err_clr,
    output logic [7:0]           err_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_t;

    typedef struct packed {
        logic [W-1:0]     data;
        logic             aux;
        logic             zero;
        logic             illegal;
        logic [OPC_W-1:0] opc;
    } entry_t;

    occ_t   state;
    entry_t head;
    entry_t skid;
    entry_t sel;

    logic in_xfer;
    logic out_xfer;
    logic legal;

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    // Build the candidate entry from the current opcode; only legal opcodes
    // match a slice, so an out-of-range opcode falls through to data=0.
    always_comb begin
        sel.data    = '0;
        sel.aux     = 1'b0;
        sel.opc     = in_opc;
        legal       = 1'b0;
        for (int k = 0; k < NUM_OPS; k++) begin
            if (in_opc == OPC_W'(k)) begin
                sel.data = res_bus[k*W +: W];
                sel.aux  = aux_bus[k];
                legal    = 1'b1;
            end
        end
        sel.illegal = !legal;
        sel.zero    = legal && (sel.data == '0);
    end

    // Occupancy FSM; buffer contents, out_valid and in_ready are all registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            head      <= '0;
            skid      <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_xfer) begin
                        head      <= sel;
                        out_valid <= 1'b1;
                        in_ready  <= 1'b1;
                        state     <= ONE;
                    end
                end
                ONE: begin
                    case ({in_xfer, out_xfer})
                        2'b10: begin
                            skid     <= sel;
                            in_ready <= 1'b0;
                            state    <= TWO;
                        end
                        2'b01: begin
                            out_valid <= 1'b0;
                            in_ready  <= 1'b1;
                            state     <= EMPTY;
                        end
                        2'b11: begin
                            head  <= sel;
                            state <= ONE;
                        end
                        default: begin
                            state <= ONE;
                        end
                    endcase
                end
                TWO: begin
                    if (out_xfer) begin
                        head     <= skid;
                        in_ready <= 1'b1;
                        state    <= ONE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= EMPTY;
                end
            endcase
        end
    end

    assign out_data    = head.data;
    assign out_aux     = head.aux;
    assign out_zero    = head.zero;
    assign out_illegal = head.illegal;
    assign out_opc     = head.opc;

`ifdef ALU_SEL_ERRCNT_EN
    // Count accepted illegal opcodes, saturating; clear wins over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= 8'd0;
        end else if (err_clr) begin
            err_cnt <= 8'd0;
        end else if (in_xfer && sel.illegal && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: doc/alu_result_sel_pipe.md
Name: alu_result_sel_pipe

Overview:
- Parametrised, registered successor to the ALU result selector.
- Selects one of NUM_OPS operation results plus its auxiliary bit (carry, borrow, multiply carry, remainder, or 0) by opcode.
- Flags zero and illegal opcodes; delivers results through a 2-entry valid/ready output buffer.
- Sits between the arithmetic/logic/comparison/knight-rider units and the display/register stage, so the source can be back-pressured.

Parameters:
- W, 8, data width of every operation result.
- NUM_OPS, 13, number of legal opcodes (0..NUM_OPS-1); must be ≤ 2**OPC_W.
- OPC_W, 4, opcode width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  opcode and result bus valid this cycle.
- in_ready  out  1  block can accept a transfer this cycle.
- in_opc  in  OPC_W  operation select.
- res_bus  in  NUM_OPS*W  packed results; op k occupies bits [k*W +: W].
- aux_bus  in  NUM_OPS  aux bit per op; bit k belongs to op k; tie unused bits 0.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer accepts head entry.
- out_data  out  W  selected result.
- out_aux  out  1  selected aux bit.
- out_zero  out  1  out_data == 0 and not illegal.
- out_illegal  out  1  opcode was ≥ NUM_OPS.
- out_opc  out  OPC_W  opcode that produced the head entry.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: out_valid=0, out_data=0, out_aux=0, out_zero=0, out_illegal=0, out_opc=0, in_ready=1, occupancy FSM=EMPTY.
- Input transfer occurs when in_valid && in_ready.
- Output transfer occurs when out_valid && out_ready.
- Selection on input transfer:
  - Opcode legal: data = res_bus[opc*W +: W], aux = aux_bus[opc], illegal = 0.
  - Opcode ≥ NUM_OPS: data = 0, aux = 0, illegal = 1, zero = 0.
  - Zero is computed at capture time.
- Storage: 2-entry buffer, head (drives out_*) and skid. Entries carry {data, aux, zero, illegal, opc}.
- Occupancy FSM:
  - EMPTY: on input transfer → ONE; entry written to head; out_valid=1 the next cycle. Latency is 1 cycle.
  - ONE:
    - Input only → TWO; entry written to skid.
    - Output only → EMPTY.
    - Both → ONE; new entry written to head.
    - Neither → hold.
  - TWO:
    - in_ready=0, so no input transfer is possible.
    - Output transfer → ONE; skid moves to head.
- in_ready is a registered output: 1 in EMPTY/ONE, 0 in TWO. No combinational path from out_ready to in_ready.
- Output stability: out_* hold stable while out_valid && !out_ready.
- Ordering: strictly FIFO. No entry is dropped or duplicated.
- in_valid when in_ready=0: ignored. The source must hold its data.
- Reset mid-operation: all entries are discarded immediately (asynchronous). The first post-reset transfer is accepted on the first clk edge after rst_n deasserts.
- Width rule: no arithmetic here. out_data is a bit-exact copy of the selected slice.

Optional Feature:
- Macro: ALU_SEL_ERRCNT_EN.
- Defined:
  - Adds output port err_cnt [7:0] and input err_clr (1 bit).
  - err_cnt increments on each input transfer with an illegal opcode, and saturates at 255.
  - err_clr has priority over increment and clears err_cnt to 0 synchronously.
  - err_cnt resets to 0 on rst_n.
- Undefined: neither port exists; behaviour is otherwise identical.

Test Plan (W=8, NUM_OPS=13):
- Reset, then in_opc=0, res_bus op0=8'h3C, aux_bus[0]=1, in_valid for 1 cycle, out_ready=1 → next cycle out_valid=1, out_data=8'h3C, out_aux=1, out_zero=0, out_opc=0.
- out_ready=0; send opc 5 (8'hA5) then opc 6 (8'h00) → in_ready drops to 0 after the 2nd transfer. Raise out_ready → outputs A5 then 00 with out_zero=1, in_ready returns to 1.
- in_opc=13 and 15 with res_bus all 8'hFF → out_data=0, out_illegal=1, out_zero=0, out_aux=0. With ALU_SEL_ERRCNT_EN, err_cnt=2; err_clr pulse → 0.
- Continuous in_valid with out_ready toggling 1,0,1,0 over 20 ops cycling opc 0..12 → every output matches the input sequence in order, no loss or duplication, out_* stable while stalled.
- Buffer in state TWO; assert rst_n=0 mid-cycle → out_valid=0 and in_ready=1 immediately, without waiting for a clk edge.
- Simultaneous input and output transfer in ONE for 10 cycles → occupancy stays ONE, 1-cycle latency throughout, in_ready=1 constant.
